// File: rtl/uart_rx_deframe_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive deframer slice:
//   PARITY_NONE / PARITY_EVEN / PARITY_ODD  - parity mode encodings
//   frame_width()                           - total serial frame width
//   uart_err_t                              - per-word error flag record
// The full word record {data, err} depends on DATA_BITS, so it is declared
// in each user module as {logic [DATA_BITS-1:0] data; uart_err_t err;}.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // start + data + optional parity + stop bits
  function automatic int frame_width(input int data_bits,
                                     input int parity_mode,
                                     input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

  typedef struct packed {
    logic parity_err;
    logic framing_err;
  } uart_err_t;

endpackage

// File: rtl/uart_rx_deframe_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Show-ahead synchronous FIFO: rd_data always presents the head entry.
// Ports:
//   clk, reset_n      - clock, synchronous active-low reset (empties FIFO)
//   push, wr_data     - write request; honoured when not full, or when full
//                       and a pop happens in the same cycle
//   pop               - remove head; ignored when empty
//   rd_data           - head entry (undefined contents when empty)
//   full, empty       - occupancy flags
//   level             - number of occupied entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // A full FIFO still accepts a write when the head leaves in the same
  // cycle: the freed slot is the one the write pointer is aiming at.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_deframe_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_deframe_fifo
// Splits a captured UART frame into start/data/parity/stop, checks parity
// and framing, queues {data, flags} in a show-ahead FIFO, and keeps sticky
// overrun status plus saturating error counters.
// Ports:
//   clk, reset_n                - clock, synchronous active-low reset
//   frame_valid, frame_in       - single-cycle strobe with complete frame
//                                 (bit0 = start, LSB first)
//   out_valid, out_ready        - head-word handshake towards the host
//   out_data                    - head data (all ones when empty)
//   out_parity_err/framing_err  - head word flags (0 when empty)
//   fifo_level                  - occupied entries
//   overrun                     - sticky: a frame was dropped (FIFO full)
//   par_err_cnt/frm_err_cnt     - saturating counts of accepted bad frames
//   ovr_cnt                     - saturating count of dropped frames
//   err_clr                     - clears overrun and counters, wins over
//                                 same-cycle events
// ---------------------------------------------------------------------------
module uart_rx_deframe_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PARITY_EVEN,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  frame_valid,
  input  logic [frame_width(DATA_BITS, PARITY_MODE, STOP_BITS)-1:0] frame_in,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [DATA_BITS-1:0]                                  out_data,
  output logic                                                  out_parity_err,
  output logic                                                  out_framing_err,
  output logic [$clog2(FIFO_DEPTH):0]                           fifo_level,
  output logic                                                  overrun,
  output logic [CNT_W-1:0]                                      par_err_cnt,
  output logic [CNT_W-1:0]                                      frm_err_cnt,
  output logic [CNT_W-1:0]                                      ovr_cnt,
  input  logic                                                  err_clr
);

  localparam int FRAME_W = frame_width(DATA_BITS, PARITY_MODE, STOP_BITS);
  // Without parity this index lands on the first stop bit; the value is
  // then ignored by the parity check.
  localparam int PAR_IDX = DATA_BITS + 1;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    uart_err_t            err;
  } word_t;

  logic                 start_bit;
  logic [DATA_BITS-1:0] data_bits;
  logic                 parity_bit;
  logic [STOP_BITS-1:0] stop_bits;
  word_t                push_word;
  word_t                head_word;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop_fire;
  logic                 drop;
  logic                 accept;

  assign start_bit  = frame_in[0];
  assign data_bits  = frame_in[DATA_BITS:1];
  assign parity_bit = frame_in[PAR_IDX];
  assign stop_bits  = frame_in[FRAME_W-1 -: STOP_BITS];

  always_comb begin
    push_word.data            = data_bits;
    push_word.err.framing_err = start_bit | ~(&stop_bits);
    push_word.err.parity_err  = 1'b0;
    if (PARITY_MODE == PARITY_EVEN)
      push_word.err.parity_err = ^{data_bits, parity_bit};
    else if (PARITY_MODE == PARITY_ODD)
      push_word.err.parity_err = ~(^{data_bits, parity_bit});
  end

  uart_sync_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (frame_valid),
    .wr_data (push_word),
    .pop     (out_ready),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Mirrors the FIFO's own accept rule: full only drops when nothing leaves.
  assign out_valid = ~fifo_empty;
  assign pop_fire  = out_valid & out_ready;
  assign drop      = frame_valid & fifo_full & ~pop_fire;
  assign accept    = frame_valid & ~drop;

  always_comb begin
    out_data        = '1;
    out_parity_err  = 1'b0;
    out_framing_err = 1'b0;
    if (!fifo_empty) begin
      out_data        = head_word.data;
      out_parity_err  = head_word.err.parity_err;
      out_framing_err = head_word.err.framing_err;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // err_clr shares the reset branch so it overrides any same-cycle event.
  always_ff @(posedge clk) begin
    if (!reset_n || err_clr) begin
      overrun     <= 1'b0;
      par_err_cnt <= '0;
      frm_err_cnt <= '0;
      ovr_cnt     <= '0;
    end else begin
      if (accept && push_word.err.parity_err)  par_err_cnt <= sat_inc(par_err_cnt);
      if (accept && push_word.err.framing_err) frm_err_cnt <= sat_inc(frm_err_cnt);
      if (drop) begin
        overrun <= 1'b1;
        ovr_cnt <= sat_inc(ovr_cnt);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframe_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframe_fifo
// Directed test of uart_rx_deframe_fifo (8 data bits, even parity, 1 stop,
// depth 4). Counters are 2 bits wide so saturation is reachable quickly.
// A queue-based reference model is compared against every output on each
// falling edge; directed literal checks pin the model's expectations.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframe_fifo;

  localparam int DATA_BITS   = 8;
  localparam int PARITY_MODE = 1;
  localparam int STOP_BITS   = 1;
  localparam int FIFO_DEPTH  = 4;
  localparam int CNT_W       = 2;
  localparam int FRAME_W     = 11;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 frame_valid;
  logic [FRAME_W-1:0]   frame_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_parity_err;
  logic                 out_framing_err;
  logic [2:0]           fifo_level;
  logic                 overrun;
  logic [CNT_W-1:0]     par_err_cnt;
  logic [CNT_W-1:0]     frm_err_cnt;
  logic [CNT_W-1:0]     ovr_cnt;
  logic                 err_clr;

  always #5 clk = ~clk;

  uart_rx_deframe_fifo #(
    .DATA_BITS   (DATA_BITS),
    .PARITY_MODE (PARITY_MODE),
    .STOP_BITS   (STOP_BITS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_valid     (frame_valid),
    .frame_in        (frame_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_parity_err  (out_parity_err),
    .out_framing_err (out_framing_err),
    .fifo_level      (fifo_level),
    .overrun         (overrun),
    .par_err_cnt     (par_err_cnt),
    .frm_err_cnt     (frm_err_cnt),
    .ovr_cnt         (ovr_cnt),
    .err_clr         (err_clr)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int data;
    bit perr;
    bit ferr;
  } mword_t;

  mword_t mq[$];
  bit     m_ovr;
  int     m_par;
  int     m_frm;
  int     m_ovrc;
  bit     model_live = 1'b0;
  bit     m_popping;
  bit     m_room;
  mword_t m_word;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference decode straight from the frame layout rules.
  function automatic mword_t decode(input logic [FRAME_W-1:0] f);
    mword_t w;
    int ones;
    w.data = 0;
    ones   = 0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (f[1+i]) begin
        w.data += (1 << i);
        ones++;
      end
    end
    if (f[DATA_BITS+1]) ones++;
    w.perr = (ones % 2) != 0;
    w.ferr = (f[0] != 1'b0) || (f[FRAME_W-1] != 1'b1);
    return w;
  endfunction

  // Builds a frame with correct even parity, then corrupts selected fields.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] d,
                                                    input bit par_bad,
                                                    input bit start_bad,
                                                    input bit stop_bad);
    int  ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    par = (ones % 2 == 1);
    if (par_bad) par = ~par;
    return {~stop_bad, par, d, start_bad};
  endfunction

  function automatic int sat(input int v);
    return (v == CNT_MAX) ? v : v + 1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_ovr      = 1'b0;
      m_par      = 0;
      m_frm      = 0;
      m_ovrc     = 0;
      model_live = 1'b1;
    end else begin
      m_popping = (mq.size() > 0) && out_ready;
      m_room    = (mq.size() < FIFO_DEPTH) || m_popping;
      if (m_popping) void'(mq.pop_front());
      if (frame_valid) begin
        m_word = decode(frame_in);
        if (m_room) begin
          mq.push_back(m_word);
          if (m_word.perr) m_par = sat(m_par);
          if (m_word.ferr) m_frm = sat(m_frm);
        end else begin
          m_ovr  = 1'b1;
          m_ovrc = sat(m_ovrc);
        end
      end
      if (err_clr) begin
        m_ovr  = 1'b0;
        m_par  = 0;
        m_frm  = 0;
        m_ovrc = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("model out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        checkOutput("model out_data", out_data, mq[0].data);
        checkOutput("model parity_err", out_parity_err, mq[0].perr);
        checkOutput("model framing_err", out_framing_err, mq[0].ferr);
      end else begin
        checkOutput("model empty out_data", out_data, 32'hFF);
        checkOutput("model empty parity_err", out_parity_err, 0);
        checkOutput("model empty framing_err", out_framing_err, 0);
      end
      checkOutput("model fifo_level", fifo_level, mq.size());
      checkOutput("model overrun", overrun, m_ovr);
      checkOutput("model par_err_cnt", par_err_cnt, m_par);
      checkOutput("model frm_err_cnt", frm_err_cnt, m_frm);
      checkOutput("model ovr_cnt", ovr_cnt, m_ovrc);
    end
  end

  task automatic applyStimulus(input bit fv, input logic [FRAME_W-1:0] f,
                               input bit rdy, input bit clr);
    frame_valid = fv;
    frame_in    = f;
    out_ready   = rdy;
    err_clr     = clr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_valid = 1'b0;
    frame_in    = '0;
    out_ready   = 1'b0;
    err_clr     = 1'b0;
    applyStimulus(0, '0, 0, 0);
    applyStimulus(0, '0, 0, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 32'hFF);
    checkOutput("reset fifo_level", fifo_level, 0);
    reset_n = 1'b1;
    applyStimulus(0, '0, 0, 0);

    // good frame, then pop it
    applyStimulus(1, 11'h54A, 0, 0);
    checkOutput("good out_valid", out_valid, 1);
    checkOutput("good out_data", out_data, 32'hA5);
    checkOutput("good parity_err", out_parity_err, 0);
    checkOutput("good framing_err", out_framing_err, 0);
    checkOutput("good fifo_level", fifo_level, 1);
    applyStimulus(0, '0, 1, 0);
    checkOutput("popped out_valid", out_valid, 0);
    checkOutput("popped out_data", out_data, 32'hFF);

    // parity error
    applyStimulus(1, 11'h74A, 0, 0);
    checkOutput("perr out_data", out_data, 32'hA5);
    checkOutput("perr parity_err", out_parity_err, 1);
    checkOutput("perr framing_err", out_framing_err, 0);
    checkOutput("perr par_err_cnt", par_err_cnt, 1);
    applyStimulus(0, '0, 1, 0);

    // framing errors: bad stop then bad start
    applyStimulus(1, 11'h14A, 0, 0);
    checkOutput("bad stop framing_err", out_framing_err, 1);
    checkOutput("bad stop frm_err_cnt", frm_err_cnt, 1);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(1, 11'h54B, 0, 0);
    checkOutput("bad start framing_err", out_framing_err, 1);
    checkOutput("bad start parity_err", out_parity_err, 0);
    checkOutput("bad start frm_err_cnt", frm_err_cnt, 2);
    applyStimulus(0, '0, 1, 0);

    // overrun: five pushes into depth four
    for (int i = 0; i < 5; i++)
      applyStimulus(1, make_frame(8'((i + 1) * 'h11), 0, 0, 0), 0, 0);
    checkOutput("ovr fifo_level", fifo_level, 4);
    checkOutput("ovr overrun", overrun, 1);
    checkOutput("ovr ovr_cnt", ovr_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovr drain order", out_data, (i + 1) * 'h11);
      applyStimulus(0, '0, 1, 0);
    end
    checkOutput("ovr drained out_valid", out_valid, 0);

    // clear, then full with simultaneous push and pop
    applyStimulus(0, '0, 0, 1);
    checkOutput("clr overrun", overrun, 0);
    checkOutput("clr ovr_cnt", ovr_cnt, 0);
    checkOutput("clr frm_err_cnt", frm_err_cnt, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, make_frame(8'('h61 + i), 0, 0, 0), 0, 0);
    applyStimulus(1, make_frame(8'h65, 0, 0, 0), 1, 0);
    checkOutput("pushpop fifo_level", fifo_level, 4);
    checkOutput("pushpop overrun", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pushpop drain order", out_data, 'h62 + i);
      applyStimulus(0, '0, 1, 0);
    end

    // err_clr in the same cycle as a parity-error frame
    applyStimulus(1, make_frame(8'h3C, 1, 0, 0), 0, 1);
    checkOutput("clr+perr par_err_cnt", par_err_cnt, 0);
    checkOutput("clr+perr out_data", out_data, 32'h3C);
    checkOutput("clr+perr parity_err", out_parity_err, 1);
    applyStimulus(1, make_frame(8'h5A, 0, 0, 0), 0, 0);
    applyStimulus(1, make_frame(8'h0F, 0, 1, 0), 0, 0);
    checkOutput("pre-reset fifo_level", fifo_level, 3);

    // reset mid-operation with a frame in the reset cycle
    reset_n = 1'b0;
    applyStimulus(1, make_frame(8'h77, 0, 0, 0), 0, 0);
    checkOutput("midreset fifo_level", fifo_level, 0);
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset out_data", out_data, 32'hFF);
    checkOutput("midreset frm_err_cnt", frm_err_cnt, 0);
    reset_n = 1'b1;
    applyStimulus(0, '0, 0, 0);

    // saturation of a 2-bit counter
    for (int i = 0; i < 5; i++)
      applyStimulus(1, make_frame(8'('h80 + i), 1, 0, 0), 1, 0);
    checkOutput("sat par_err_cnt", par_err_cnt, 3);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframe_fifo.md
Name: uart_rx_deframe_fifo

Overview:
Parametrised successor to the UART receive deframer. Takes a complete serial frame captured by the receive SIPO and splits it into start, data, optional parity and stop bits. Checks the parity and framing of each frame and queues the data with per-word error flags in an internal FIFO. Sits between the RX SIPO and the host/bus interface, which drains words with a valid/ready handshake and monitors sticky status and saturating error counters.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal 1..2.
FIFO_DEPTH, 4, entries in the word queue; power of two, ≥2.
CNT_W, 8, width of each error counter.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset_n  in  1  reset: synchronous, active-low.
frame_valid  in  1  single-cycle strobe; frame_in is complete this cycle.
frame_in  in  FRAME_W  captured frame. FRAME_W = 1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS.
out_valid  out  1  head word available.
out_ready  in  1  consumer accepts head word.
out_data  out  DATA_BITS  head word data.
out_parity_err  out  1  head word failed parity check.
out_framing_err  out  1  head word had a bad start or stop bit.
fifo_level  out  clog2(FIFO_DEPTH)+1  occupied entries.
overrun  out  1  sticky; a frame was dropped because the FIFO was full.
par_err_cnt  out  CNT_W  saturating count of parity-error frames accepted.
frm_err_cnt  out  CNT_W  saturating count of framing-error frames accepted.
ovr_cnt  out  CNT_W  saturating count of dropped frames.
err_clr  in  1  clears overrun and all three counters.

Behaviour:
- Frame layout, LSB first:
  - bit0 = start bit.
  - bits [DATA_BITS:1] = data, LSB first.
  - next bit = parity, present only if PARITY_MODE != 0.
  - top STOP_BITS bits = stop bits.
- Checks are combinational on frame_in:
  - framing_err = (start != 0) OR (any stop bit != 1).
  - Even parity: parity_err = XOR(data, parity) != 0.
  - Odd parity: parity_err = XOR(data, parity) != 1.
  - No parity: parity_err = 0.
- Push: on a rising edge with frame_valid=1, {data, parity_err, framing_err} is written to the FIFO tail if the FIFO is not full.
- Pop: when out_valid && out_ready, the head is removed.
- FIFO is show-ahead. out_* reflect the head whenever out_valid=1. When empty, out_data = all ones and both error flags = 0.
- Latency: frame accepted at edge N into an empty FIFO gives out_valid=1 after edge N; it is visible in cycle N+1.
- Full with simultaneous push and pop: both occur, level unchanged, no overrun.
- Full with push and no pop: frame dropped, overrun set to 1, ovr_cnt incremented. The FIFO contents are unchanged.
- Empty with pop request: ignored, since out_valid=0. Pointers wrap modulo FIFO_DEPTH.
- Error counters:
  - par_err_cnt and frm_err_cnt increment only for accepted frames (not dropped ones).
  - A frame with both errors increments both counters.
  - All counters saturate at 2^CNT_W−1.
- err_clr takes precedence: in a cycle with err_clr=1, overrun and all counters go to 0 and any same-cycle error event is not counted. The FIFO is unaffected.
- frame_valid held high for several cycles counts as one push per cycle. The source must guarantee a single-cycle strobe.
- Reset (reset_n=0 at an edge), including mid-operation:
  - FIFO emptied: fifo_level=0, out_valid=0, out_data=all ones, error flags 0.
  - overrun=0 and all counters 0.
  - A frame_valid in the reset cycle is discarded.

Decomposition:
- Shared package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - Frame-width function FRAME_W(DATA_BITS, PARITY_MODE, STOP_BITS).
  - Word record type {data, parity_err, framing_err}.
- One natural sub-module: uart_sync_fifo.
  - Parametrised width/depth, show-ahead, push/pop/full/empty/level.
- Frame checking and counters stay in the top module.

Test Plan:
Base configuration for all scenarios: DATA_BITS=8, PARITY_MODE=1 (even), STOP_BITS=1, FIFO_DEPTH=4, so FRAME_W=11.
1. Good frame: frame_in=11'h54A (data 0xA5), pulse, out_ready=0 → next cycle out_valid=1, out_data=8'hA5, both error flags 0, fifo_level=1. Then out_ready=1 for 1 cycle → out_valid=0, out_data=8'hFF.
2. Parity error: frame_in=11'h74A → out_data=8'hA5, out_parity_err=1, out_framing_err=0, par_err_cnt=1.
3. Framing error:
   - 11'h14A (bad stop) → out_framing_err=1, frm_err_cnt=1.
   - Then 11'h54B (bad start) → frm_err_cnt=2.
4. Overrun: out_ready=0, push 5 good frames → fifo_level=4, overrun=1, ovr_cnt=1. Draining returns the first 4 frames in order.
5. Full with simultaneous push and pop: FIFO full, frame_valid=1 and out_ready=1 in the same cycle → fifo_level stays 4, overrun stays 0, new word is last out.
6. Clear, reset and saturation:
   - err_clr in the same cycle as a parity-error frame → par_err_cnt=0, word still queued with its flag.
   - reset_n=0 with 3 words queued → fifo_level=0, out_valid=0, all counters 0.
   - With CNT_W=2, 5 parity-error frames → par_err_cnt=3.
